// File: rtl/pkt_verdict_pipe.sv
// Delays a 64-bit receive stream by DELAY+1 cycles while a key lookup decides per packet
// whether it is forwarded or suppressed. Counters exist only with PKT_VERDICT_STATS_EN.
module pkt_verdict_pipe #(
  parameter int unsigned KEY_SIZE = 96,
  parameter int unsigned DELAY    = 16,
  parameter logic [15:0] DNS_PORT = 16'd53
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic                s_axis_rx_tvalid,
  input  logic [63:0]         s_axis_rx_tdata,
  input  logic [7:0]          s_axis_rx_tkeep,
  input  logic                s_axis_rx_tlast,
  output logic                m_axis_tx_tvalid,
  output logic [63:0]         m_axis_tx_tdata,
  output logic [7:0]          m_axis_tx_tkeep,
  output logic                m_axis_tx_tlast,
  output logic [KEY_SIZE-1:0] in_key,
  output logic [3:0]          in_flag,
  output logic                in_valid,
  input  logic                out_valid,
  input  logic [3:0]          out_flag,
  output logic [31:0]         pkt_pass_cnt,
  output logic [31:0]         pkt_drop_cnt,
  output logic [31:0]         late_cnt,
  output logic [7:0]          debug
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned BEAT_W = 10;
  localparam int unsigned AGE_W  = 7;
  localparam int unsigned PAD_W  = KEY_SIZE - 80;
  localparam logic [BEAT_W-1:0] BEAT_MAX = 10'd1023;

  localparam logic [1:0] O_IDLE = 2'd0;
  localparam logic [1:0] O_PASS = 2'd1;
  localparam logic [1:0] O_DROP = 2'd2;

  logic [BEAT_W-1:0] r_beat_idx;
  logic [15:0]       r_ethertype;
  logic [7:0]        r_proto;
  logic [31:0]       r_src_ip;
  logic [31:0]       r_dst_ip;
  logic [15:0]       r_dst_port;
  logic              r_qualified;
  logic              r_pending;
  logic [AGE_W-1:0]  r_age;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [DELAY-1:0]  r_dl_valid, r_dl_last, r_dl_sop, r_dl_drop;
  logic [DATA_W-1:0] r_dl_data [DELAY];
  logic [KEEP_W-1:0] r_dl_keep [DELAY];

  logic w_sop_in, w_lookup, w_in_time, w_drop_hit, w_late;
  logic w_l_valid, w_l_sop, w_l_last, w_l_drop, w_fwd, w_decide;
  logic w_unused_bits;

  assign w_sop_in = s_axis_rx_tvalid && (r_beat_idx == '0);
  assign w_lookup = s_axis_rx_tvalid && r_qualified && (r_beat_idx == 10'd7);

  // Beat counter and header capture, network byte order swapped to host order
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_beat_idx  <= '0;
      r_ethertype <= '0;
      r_proto     <= '0;
      r_src_ip    <= '0;
      r_dst_ip    <= '0;
      r_dst_port  <= '0;
      r_qualified <= 1'b0;
    end else if (s_axis_rx_tvalid) begin
      if (s_axis_rx_tlast)              r_beat_idx <= '0;
      else if (r_beat_idx != BEAT_MAX)  r_beat_idx <= r_beat_idx + 10'd1;
      case (r_beat_idx)
        10'd0: r_qualified <= 1'b0;
        10'd1: r_ethertype <= {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
        10'd2: r_proto     <= s_axis_rx_tdata[63:56];
        10'd3: begin
          r_src_ip        <= {s_axis_rx_tdata[23:16], s_axis_rx_tdata[31:24],
                              s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
          r_dst_ip[31:16] <= {s_axis_rx_tdata[55:48], s_axis_rx_tdata[63:56]};
        end
        10'd4: begin
          r_dst_ip[15:0] <= {s_axis_rx_tdata[7:0], s_axis_rx_tdata[15:8]};
          r_dst_port     <= {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
        end
        10'd5: r_qualified <= (r_ethertype == 16'h0800) && (r_proto == 8'h11) &&
                              (r_dst_port == DNS_PORT);
        default: ;
      endcase
    end
  end

  assign in_valid = w_lookup;
  assign in_flag  = w_lookup ? 4'b0011 : 4'b0000;
  assign in_key   = w_lookup ? {r_src_ip, r_dst_ip, r_dst_port, {PAD_W{1'b0}}} : '0;

  // The SOP of the pending packet sits in delay stage r_age
  assign w_in_time  = r_age < AGE_W'(DELAY);
  assign w_drop_hit = r_pending && out_valid && (out_flag[2:1] == 2'b10) && w_in_time;
  assign w_late     = r_pending && out_valid && !w_in_time;

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_age     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_sop_in)                     r_age <= '0;
      else if (r_age != {AGE_W{1'b1}})  r_age <= r_age + AGE_W'(1);
      if (w_lookup)                     r_pending <= 1'b1;
      else if (w_sop_in)                r_pending <= 1'b0;
      else if (r_pending && out_valid)  r_pending <= 1'b0;
    end
  end

  // Delay line; a drop verdict follows its SOP into the next stage
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_dl_valid <= '0;
      r_dl_last  <= '0;
      r_dl_sop   <= '0;
      r_dl_drop  <= '0;
      for (int i = 0; i < int'(DELAY); i++) begin
        r_dl_data[i] <= '0;
        r_dl_keep[i] <= '0;
      end
    end else begin
      r_dl_valid   <= {r_dl_valid[DELAY-2:0], s_axis_rx_tvalid};
      r_dl_last    <= {r_dl_last[DELAY-2:0], s_axis_rx_tvalid & s_axis_rx_tlast};
      r_dl_sop     <= {r_dl_sop[DELAY-2:0], w_sop_in};
      r_dl_data[0] <= s_axis_rx_tvalid ? s_axis_rx_tdata : '0;
      r_dl_keep[0] <= s_axis_rx_tvalid ? s_axis_rx_tkeep : '0;
      r_dl_drop[0] <= 1'b0;
      for (int i = 1; i < int'(DELAY); i++) begin
        r_dl_data[i] <= r_dl_data[i-1];
        r_dl_keep[i] <= r_dl_keep[i-1];
        r_dl_drop[i] <= r_dl_drop[i-1] | (w_drop_hit && (r_age == AGE_W'(i-1)));
      end
    end
  end

  assign w_l_valid = r_dl_valid[DELAY-1];
  assign w_l_sop   = r_dl_sop[DELAY-1];
  assign w_l_last  = r_dl_last[DELAY-1];
  assign w_l_drop  = r_dl_drop[DELAY-1] | (w_drop_hit && (r_age == AGE_W'(DELAY-1)));

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) r_state <= O_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Per-packet verdict taken at the SOP beat leaving the delay line
  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      O_IDLE: if (w_l_valid && w_l_sop) begin
        w_decide = 1'b1;
        w_fwd    = !w_l_drop;
        if (!w_l_last) w_state_nxt = w_l_drop ? O_DROP : O_PASS;
      end
      O_PASS: begin
        w_fwd = w_l_valid;
        if (w_l_valid && w_l_last) w_state_nxt = O_IDLE;
      end
      O_DROP: if (w_l_valid && w_l_last) w_state_nxt = O_IDLE;
      default: w_state_nxt = O_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      m_axis_tx_tvalid <= 1'b0;
      m_axis_tx_tdata  <= '0;
      m_axis_tx_tkeep  <= '0;
      m_axis_tx_tlast  <= 1'b0;
    end else begin
      m_axis_tx_tvalid <= w_fwd;
      m_axis_tx_tdata  <= w_fwd ? r_dl_data[DELAY-1] : '0;
      m_axis_tx_tkeep  <= w_fwd ? r_dl_keep[DELAY-1] : '0;
      m_axis_tx_tlast  <= w_fwd & w_l_last;
    end
  end

`ifdef PKT_VERDICT_STATS_EN
  logic [31:0] r_pass_cnt, r_drop_cnt, r_late_cnt;

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
      r_late_cnt <= '0;
    end else begin
      if (w_decide && !w_l_drop) r_pass_cnt <= r_pass_cnt + 32'd1;
      if (w_decide && w_l_drop)  r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_late)                r_late_cnt <= r_late_cnt + 32'd1;
    end
  end

  assign pkt_pass_cnt = r_pass_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
  assign late_cnt     = r_late_cnt;
`else
  assign pkt_pass_cnt = 32'd0;
  assign pkt_drop_cnt = 32'd0;
  assign late_cnt     = 32'd0;
`endif

  assign w_unused_bits = ^{out_flag[3], out_flag[0], w_late, w_decide};
  assign debug = {r_state, r_pending, r_qualified, r_beat_idx[3:0]};

endmodule

// File: tb/tb_pkt_verdict_pipe.sv
// Directed bench for pkt_verdict_pipe: verdict scenarios, latency, reset and back-to-back packets.
module tb_pkt_verdict_pipe;

  localparam int unsigned KEY_W = 96;
  localparam int LAT = 17;
`ifdef PKT_VERDICT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] SIP  = 32'hC0A8_0001;
  localparam logic [31:0] SIP2 = 32'hC0A8_0102;
  localparam logic [31:0] DIP  = 32'h0A00_0035;

  logic              clk156 = 1'b0;
  logic              eth_rst_n = 1'b0;
  logic              s_axis_rx_tvalid = 1'b0;
  logic [63:0]       s_axis_rx_tdata = '0;
  logic [7:0]        s_axis_rx_tkeep = '0;
  logic              s_axis_rx_tlast = 1'b0;
  logic              m_axis_tx_tvalid;
  logic [63:0]       m_axis_tx_tdata;
  logic [7:0]        m_axis_tx_tkeep;
  logic              m_axis_tx_tlast;
  logic [KEY_W-1:0]  in_key;
  logic [3:0]        in_flag;
  logic              in_valid;
  logic              out_valid = 1'b0;
  logic [3:0]        out_flag = '0;
  logic [31:0]       pkt_pass_cnt, pkt_drop_cnt, late_cnt;
  logic [7:0]        debug;

  pkt_verdict_pipe #(.KEY_SIZE(KEY_W), .DELAY(16), .DNS_PORT(16'd53)) dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tdata(s_axis_rx_tdata),
    .s_axis_rx_tkeep(s_axis_rx_tkeep), .s_axis_rx_tlast(s_axis_rx_tlast),
    .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tdata(m_axis_tx_tdata),
    .m_axis_tx_tkeep(m_axis_tx_tkeep), .m_axis_tx_tlast(m_axis_tx_tlast),
    .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
    .out_valid(out_valid), .out_flag(out_flag),
    .pkt_pass_cnt(pkt_pass_cnt), .pkt_drop_cnt(pkt_drop_cnt), .late_cnt(late_cnt),
    .debug(debug)
  );

  always #5 clk156 = ~clk156;

  typedef struct { int cyc; logic [63:0] d; logic [7:0] k; logic l; } obeat_t;
  typedef struct { int cyc; logic [KEY_W-1:0] key; logic [3:0] flag; } req_t;

  obeat_t      mq[$];
  req_t        rq[$];
  bit          bv[$];
  logic [63:0] bd[$];
  logic [7:0]  bk[$];
  bit          bl[$];
  int cyc = 0;
  int stray = 0;
  int n_cmp = 0;
  int n_err = 0;
  int c0;

  always @(posedge clk156) cyc <= cyc + 1;

  // Output and lookup-request monitor, sampled mid-cycle
  always @(negedge clk156) begin
    if (m_axis_tx_tvalid)
      mq.push_back('{cyc, m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast});
    else if (m_axis_tx_tdata != '0 || m_axis_tx_tkeep != '0 || m_axis_tx_tlast)
      stray++;
    if (in_valid) rq.push_back('{cyc, in_key, in_flag});
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    s_axis_rx_tvalid = 1'b0; s_axis_rx_tdata = '0; s_axis_rx_tkeep = '0;
    s_axis_rx_tlast = 1'b0;  out_valid = 1'b0;      out_flag = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk156); #1; drive_idle(); end
  endtask

  task automatic clr_stim();
    bv.delete(); bd.delete(); bk.delete(); bl.delete();
  endtask

  task automatic new_scn();
    @(posedge clk156); #1;
    eth_rst_n = 1'b0; drive_idle();
    @(posedge clk156); #1;
    eth_rst_n = 1'b1;
    mq.delete(); rq.delete(); clr_stim();
  endtask

  // Builds a frame in wire byte order and appends its beats (byte 0 in bits [7:0])
  task automatic add_pkt(input logic [15:0] et, input logic [7:0] pr, input logic [31:0] sip,
                         input logic [31:0] dip, input logic [15:0] dp, input int nb,
                         input logic [7:0] seed);
    logic [7:0]  by [128];
    logic [63:0] d;
    for (int j = 0; j < 128; j++) by[j] = seed + 8'(j);
    by[12] = et[15:8];   by[13] = et[7:0];   by[23] = pr;
    by[26] = sip[31:24]; by[27] = sip[23:16]; by[28] = sip[15:8]; by[29] = sip[7:0];
    by[30] = dip[31:24]; by[31] = dip[23:16]; by[32] = dip[15:8]; by[33] = dip[7:0];
    by[36] = dp[15:8];   by[37] = dp[7:0];
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int j = 0; j < 8; j++) d[8*j +: 8] = by[8*b+j];
      bv.push_back(1'b1); bd.push_back(d);
      bk.push_back((b == nb-1) ? 8'h3F : 8'hFF);
      bl.push_back(b == nb-1);
    end
  endtask

  task automatic add_gap(input int n);
    repeat (n) begin bv.push_back(1'b0); bd.push_back('0); bk.push_back('0); bl.push_back(1'b0); end
  endtask

  // Plays the beat list from cycle c0; optional single reply at offset rep_k
  task automatic run_stim(input int rep_k, input logic [3:0] rep_flag, input int ncyc,
                          output int cs);
    cs = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk156); #1;
      if (k == 0) cs = cyc;
      if (k < bv.size() && bv[k]) begin
        s_axis_rx_tvalid = 1'b1; s_axis_rx_tdata = bd[k];
        s_axis_rx_tkeep  = bk[k]; s_axis_rx_tlast = bl[k];
      end else begin
        s_axis_rx_tvalid = 1'b0; s_axis_rx_tdata = '0; s_axis_rx_tkeep = '0; s_axis_rx_tlast = 1'b0;
      end
      out_valid = (k == rep_k);
      out_flag  = (k == rep_k) ? rep_flag : 4'h0;
    end
  endtask

  task automatic check_fwd(input string tag, input int cs, input int first, input int n);
    chk({tag, " beats"}, 128'(mq.size()), 128'(n));
    for (int i = 0; i < n && i < mq.size(); i++) begin
      chk({tag, " data"}, mq[i].d, bd[first+i]);
      chk({tag, " keep"}, mq[i].k, bk[first+i]);
      chk({tag, " last"}, mq[i].l, bl[first+i]);
      chk({tag, " cycle"}, 128'(mq[i].cyc), 128'(cs + first + i + LAT));
    end
    chk({tag, " stray"}, 128'(stray), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    repeat (3) @(posedge clk156);
    #1;
    chk("rst tvalid", m_axis_tx_tvalid, 1'b0);
    chk("rst tdata", m_axis_tx_tdata, 64'h0);
    chk("rst in_valid", in_valid, 1'b0);
    chk("rst in_key", in_key, '0);
    chk("rst debug", debug, 8'h00);
    chk("rst pass_cnt", pkt_pass_cnt, 32'd0);
    eth_rst_n = 1'b1;

    // Qualified packet, drop reply at age 9
    new_scn();
    add_pkt(16'h0800, 8'h11, SIP, DIP, 16'd53, 10, 8'h10);
    run_stim(10, 4'b0100, 32, c0);
    chk("s1 req count", 128'(rq.size()), 128'd1);
    if (rq.size() > 0) begin
      chk("s1 req cycle", 128'(rq[0].cyc), 128'(c0 + 7));
      chk("s1 req key", rq[0].key, {SIP, DIP, 16'd53, 16'h0});
      chk("s1 req flag", rq[0].flag, 4'b0011);
    end
    chk("s1 beats", 128'(mq.size()), 128'd0);
    chk("s1 drop_cnt", pkt_drop_cnt, STATS ? 32'd1 : 32'd0);
    chk("s1 pass_cnt", pkt_pass_cnt, 32'd0);
    chk("s1 debug", debug, 8'h10);

    // Pass reply
    new_scn();
    add_pkt(16'h0800, 8'h11, SIP, DIP, 16'd53, 10, 8'h20);
    run_stim(10, 4'b0010, 32, c0);
    check_fwd("s2", c0, 0, 10);
    chk("s2 pass_cnt", pkt_pass_cnt, STATS ? 32'd1 : 32'd0);

    // Drop reply at age 16 is late
    new_scn();
    add_pkt(16'h0800, 8'h11, SIP, DIP, 16'd53, 10, 8'h30);
    run_stim(17, 4'b0100, 32, c0);
    check_fwd("s3", c0, 0, 10);
    chk("s3 late_cnt", late_cnt, STATS ? 32'd1 : 32'd0);
    chk("s3 drop_cnt", pkt_drop_cnt, 32'd0);

    // Drop reply at age 15 still in time
    new_scn();
    add_pkt(16'h0800, 8'h11, SIP, DIP, 16'd53, 10, 8'h40);
    run_stim(16, 4'b0100, 32, c0);
    chk("s4 beats", 128'(mq.size()), 128'd0);
    chk("s4 late_cnt", late_cnt, 32'd0);

    // ARP frame, stray drop reply with nothing pending
    new_scn();
    add_pkt(16'h0806, 8'h11, SIP, DIP, 16'd53, 4, 8'h50);
    run_stim(2, 4'b0100, 26, c0);
    chk("s5 req count", 128'(rq.size()), 128'd0);
    check_fwd("s5", c0, 0, 4);

    // UDP to port 54 is not looked up
    new_scn();
    add_pkt(16'h0800, 8'h11, SIP, DIP, 16'd54, 10, 8'h60);
    run_stim(10, 4'b0100, 32, c0);
    chk("s6 req count", 128'(rq.size()), 128'd0);
    check_fwd("s6", c0, 0, 10);

    // Reset while one frame is leaving and another is at beat 5
    new_scn();
    add_pkt(16'h0806, 8'h06, SIP, DIP, 16'd80, 4, 8'h70);
    add_gap(9);
    add_pkt(16'h0800, 8'h11, SIP, DIP, 16'd53, 10, 8'h80);
    run_stim(-1, 4'h0, 18, c0);
    @(posedge clk156); #1;
    chk("s7 pre tvalid", m_axis_tx_tvalid, 1'b1);
    chk("s7 pre tdata", m_axis_tx_tdata, bd[1]);
    eth_rst_n = 1'b0; drive_idle();
    #1;
    chk("s7 rst tvalid", m_axis_tx_tvalid, 1'b0);
    chk("s7 rst tdata", m_axis_tx_tdata, 64'h0);
    chk("s7 rst tlast", m_axis_tx_tlast, 1'b0);
    chk("s7 rst debug", debug, 8'h00);
    repeat (2) @(posedge clk156);
    #1;
    eth_rst_n = 1'b1;
    mq.delete();
    idle(30);
    chk("s7 residue beats", 128'(mq.size()), 128'd0);
    clr_stim();
    add_pkt(16'h0806, 8'h06, SIP, DIP, 16'd80, 4, 8'h90);
    run_stim(-1, 4'h0, 24, c0);
    check_fwd("s7 resume", c0, 0, 4);

    // Back-to-back qualified packets, first dropped
    new_scn();
    add_pkt(16'h0800, 8'h11, SIP, DIP, 16'd53, 8, 8'hA0);
    add_pkt(16'h0800, 8'h11, SIP2, DIP, 16'd53, 8, 8'hB0);
    run_stim(8, 4'b0100, 40, c0);
    chk("s8 req count", 128'(rq.size()), 128'd2);
    if (rq.size() > 1) begin
      chk("s8 req1 cycle", 128'(rq[1].cyc), 128'(c0 + 15));
      chk("s8 req1 key", rq[1].key, {SIP2, DIP, 16'd53, 16'h0});
    end
    check_fwd("s8", c0, 8, 8);
    chk("s8 drop_cnt", pkt_drop_cnt, STATS ? 32'd1 : 32'd0);
    chk("s8 pass_cnt", pkt_pass_cnt, STATS ? 32'd1 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
